// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin sharing of one register_bank control port
// between NREQ requesters. Each accepted single-word transaction drives the
// bank for RD_LAT+1 cycles, captures r_out, and pulses rsp_valid to its owner.
// Optional macro REGBANK_ARB_LOCK_EN adds req_lock, letting one requester hold
// the bank across several transactions (atomic read-modify-write).
module regbank_arbiter #(
  parameter int NREQ   = 2,
  parameter int RD_LAT = 1
) (
  input  logic               control_clk,
  input  logic               control_rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*9-1:0]  req_cs,
  input  logic [NREQ*2-1:0]  req_sel,
  input  logic [NREQ*7-1:0]  req_addr,
  input  logic [NREQ*64-1:0] req_wdata,
`ifdef REGBANK_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [63:0]        rsp_rdata,
  output logic [8:0]         cs,
  output logic [1:0]         sel,
  output logic [6:0]         addr,
  output logic [63:0]        r_in,
  output logic               we,
  input  logic [63:0]        r_out
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = 3;

  typedef enum logic [1:0] {IDLE, HOLD, CAPT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   cnt;
  logic            cur_we;
  logic [NREQ-1:0] grant;
  logic            accept;

`ifdef REGBANK_ARB_LOCK_EN
  logic            locked;
  logic            cur_lock;
  logic [PW-1:0]   lock_owner;
`endif

  // Per-requester views of the flattened request fields
  logic [8:0]  f_cs   [NREQ];
  logic [1:0]  f_sel  [NREQ];
  logic [6:0]  f_addr [NREQ];
  logic [63:0] f_wd   [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign f_cs[i]   = req_cs[9*i +: 9];
    assign f_sel[i]  = req_sel[2*i +: 2];
    assign f_addr[i] = req_addr[7*i +: 7];
    assign f_wd[i]   = req_wdata[64*i +: 64];
  end

  // Round-robin search from ptr upward with wrap; walking k downward lets the
  // nearest valid requester overwrite any farther one. Locked mode only
  // considers the lock owner.
  always_comb begin
    logic [PW:0] sum;
    grant = '0;
    gidx  = '0;
    sum   = '0;
`ifdef REGBANK_ARB_LOCK_EN
    if (locked) begin
      if (req_valid[lock_owner]) begin
        grant[lock_owner] = 1'b1;
        gidx              = lock_owner;
      end
    end else begin
`else
    begin
`endif
      for (int k = NREQ-1; k >= 0; k--) begin
        sum = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
        if (req_valid[sum[PW-1:0]]) begin
          grant                 = '0;
          grant[sum[PW-1:0]]    = 1'b1;
          gidx                  = sum[PW-1:0];
        end
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // Transaction sequencer: accept, hold bank signals for RD_LAT cycles, then
  // spend one CAPT cycle so the registered r_out can be captured
  always_ff @(posedge control_clk) begin
    if (!control_rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      cur_we     <= 1'b0;
      cs         <= '0;
      sel        <= '0;
      addr       <= '0;
      r_in       <= '0;
      we         <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
`ifdef REGBANK_ARB_LOCK_EN
      locked     <= 1'b0;
      cur_lock   <= 1'b0;
      lock_owner <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            cs     <= f_cs[gidx];
            sel    <= f_sel[gidx];
            addr   <= f_addr[gidx];
            r_in   <= req_we[gidx] ? f_wd[gidx] : '0;
            we     <= req_we[gidx];
            cur_we <= req_we[gidx];
            owner  <= gidx;
            cnt    <= CW'(RD_LAT);
            state  <= HOLD;
`ifdef REGBANK_ARB_LOCK_EN
            // pointer is frozen while a lock is held so fairness resumes
            // where it left off once the lock owner lets go
            if (!locked) ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
            cur_lock <= req_lock[gidx];
            if (req_lock[gidx]) begin
              locked     <= 1'b1;
              lock_owner <= gidx;
            end
`else
            ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
`endif
          end
        end
        HOLD: begin
          // write strobe is a single-cycle pulse; address/data keep holding
          we <= 1'b0;
          if (cnt == CW'(1)) state <= CAPT;
          else               cnt   <= cnt - 1'b1;
        end
        CAPT: begin
          rsp_rdata        <= cur_we ? '0 : r_out;
          rsp_valid[owner] <= 1'b1;
          cs               <= '0;
          sel              <= '0;
          addr             <= '0;
          r_in             <= '0;
          state            <= IDLE;
`ifdef REGBANK_ARB_LOCK_EN
          if (locked && !cur_lock) locked <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: bank model, reference model with scoreboard,
// directed scenarios plus randomized traffic. Define REGBANK_ARB_LOCK_EN to
// also exercise the lock feature.
module tb_regbank_arbiter;
  localparam int NREQ   = 2;
  localparam int RD_LAT = 3;
  localparam logic [63:0] FW_DATE = 64'h2024_0611_0000_0042;

  logic               control_clk = 1'b0;
  logic               control_rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_we = '0;
  logic [NREQ*9-1:0]  req_cs = '0;
  logic [NREQ*2-1:0]  req_sel = '0;
  logic [NREQ*7-1:0]  req_addr = '0;
  logic [NREQ*64-1:0] req_wdata = '0;
`ifdef REGBANK_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock = '0;
`endif
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [63:0]        rsp_rdata;
  logic [8:0]         cs;
  logic [1:0]         sel;
  logic [6:0]         addr;
  logic [63:0]        r_in;
  logic               we;
  logic [63:0]        r_out;

  regbank_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT)) u_dut (
    .control_clk(control_clk), .control_rst_n(control_rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_cs(req_cs),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef REGBANK_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs(cs), .sel(sel), .addr(addr), .r_in(r_in), .we(we), .r_out(r_out)
  );

  always #5 control_clk = ~control_clk;

  int cyc = 0;
  always @(posedge control_clk) cyc <= cyc + 1;

  // register_bank model: writes need a chip select, reads return after RD_LAT
  // registered stages, cs=0 reads give 0, 0x18 on bank 0 is a read-only date
  logic [63:0] bank_mem [512];
  logic [63:0] rd_pipe [RD_LAT];
  always @(posedge control_clk) begin
    if (we && cs != 9'd0) bank_mem[{sel, addr}] <= r_in;
    rd_pipe[0] <= (cs == 9'd0) ? 64'd0 :
                  (({sel, addr} == 9'h018) ? FW_DATE : bank_mem[{sel, addr}]);
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign r_out = rd_pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int owner; logic [63:0] rdata; int due; } exp_t;
  exp_t        sb[$];
  logic [63:0] ref_mem [int];
  int          ref_ptr = 0;
  logic        ref_locked = 1'b0;
  int          ref_lo = 0;
  int          acc_cnt [NREQ];
  int          acc_owner[$];
  int          acc_cyc[$];

  // Transaction currently on the bank, as seen at its accept
  logic        live = 1'b0;
  int          l_n = 0;
  logic        l_we = 1'b0;
  logic [8:0]  l_cs = '0;
  logic [1:0]  l_sel = '0;
  logic [6:0]  l_addr = '0;
  logic [63:0] l_wd = '0;

  function automatic logic busy_now();
    return live && (cyc <= l_n + RD_LAT + 1);
  endfunction

  function automatic logic [NREQ-1:0] ref_grant();
    logic [NREQ-1:0] gr;
    gr = '0;
    if (ref_locked) begin
      if (req_valid[ref_lo]) gr[ref_lo] = 1'b1;
      return gr;
    end
    for (int k = 0; k < NREQ; k++) begin
      int j = (ref_ptr + k) % NREQ;
      if (req_valid[j]) begin
        gr[j] = 1'b1;
        return gr;
      end
    end
    return gr;
  endfunction

  task automatic record_accept();
    int g; int key; exp_t e;
    logic [8:0] c; logic [1:0] s; logic [6:0] a; logic [63:0] d; logic w;
    g = 0;
    for (int k = 0; k < NREQ; k++) if (req_valid[k] && req_ready[k]) g = k;
    chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
    c = req_cs[9*g +: 9]; s = req_sel[2*g +: 2]; a = req_addr[7*g +: 7];
    d = req_wdata[64*g +: 64]; w = req_we[g];
    key = int'({s, a});
    if (w) begin
      if (c != 9'd0) ref_mem[key] = d;
      e.rdata = 64'd0;
    end else if (c == 9'd0) e.rdata = 64'd0;
    else if (key == 'h18) e.rdata = FW_DATE;
    else e.rdata = ref_mem.exists(key) ? ref_mem[key] : 64'd0;
    e.owner = g;
    e.due   = cyc + RD_LAT + 2;
    sb.push_back(e);
    live = 1'b1; l_n = cyc; l_we = w; l_cs = c; l_sel = s; l_addr = a; l_wd = d;
    acc_cnt[g]++;
    acc_owner.push_back(g);
    acc_cyc.push_back(cyc);
    if (!ref_locked) ref_ptr = (g + 1) % NREQ;
`ifdef REGBANK_ARB_LOCK_EN
    if (req_lock[g]) begin
      ref_locked = 1'b1;
      ref_lo     = g;
    end else if (ref_locked) ref_locked = 1'b0;
`endif
  endtask

  // Observer: checks bank port and grants each cycle, pushes expectations
  initial forever begin
    @(negedge control_clk);
    if (!control_rst_n) begin
      sb.delete();
      live = 1'b0; ref_ptr = 0; ref_locked = 1'b0;
    end else if (busy_now()) begin
      chk("hold_ctl", 64'({we, cs, sel, addr}),
          64'({(l_we && cyc == l_n + 1), l_cs, l_sel, l_addr}));
      chk("hold_rin", r_in, l_we ? l_wd : 64'd0);
      chk("ready_busy", 64'(req_ready), 64'd0);
    end else begin
      chk("idle_bank", 64'({we, cs, sel, addr}), 64'd0);
      chk("idle_rin", r_in, 64'd0);
      chk("ready_rr", 64'(req_ready), 64'(ref_grant()));
      if (|(req_valid & req_ready)) record_accept();
    end
  end

  // Monitor: pops and compares whenever a response pulse appears
  exp_t            e_m;
  logic [NREQ-1:0] oh;
  initial forever begin
    @(negedge control_clk);
    if (control_rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
      end else begin
        e_m = sb.pop_front();
        oh = '0;
        oh[e_m.owner] = 1'b1;
        chk("rsp_owner", 64'(rsp_valid), 64'(oh));
        chk("rsp_rdata", rsp_rdata, e_m.rdata);
        chk("rsp_cycle", 64'(cyc), 64'(e_m.due));
      end
    end
  end

  task automatic set_fields(input int i, input logic w, input logic [8:0] c,
                            input logic [1:0] s, input logic [6:0] a, input logic [63:0] d);
    req_we[i] = w;
    req_cs[9*i +: 9] = c;
    req_sel[2*i +: 2] = s;
    req_addr[7*i +: 7] = a;
    req_wdata[64*i +: 64] = d;
  endtask

  task automatic rand_fields(input int i, input bit rd_only);
    logic [8:0] c; logic [6:0] a;
    c = ($urandom_range(7, 0) == 0) ? 9'd0 : (9'd1 << $urandom_range(8, 0));
    a = ($urandom_range(4, 0) == 0) ? 7'h18 : 7'($urandom_range(5, 0));
    set_fields(i, rd_only ? 1'b0 : 1'($urandom_range(1, 0)), c,
               2'($urandom_range(1, 0)), a, {$urandom, $urandom});
  endtask

  task automatic wait_acc(input int i);
    int c0 = acc_cnt[i];
    for (int t = 0; t < 200; t++) begin
      @(posedge control_clk); #1;
      if (acc_cnt[i] != c0) return;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: req%0d never accepted", i);
  endtask

  task automatic drive(input int i, input int n, input int maxgap, input bit rd_only);
    for (int t = 0; t < n; t++) begin
      rand_fields(i, rd_only);
      req_valid[i] = 1'b1;
      wait_acc(i);
      if (maxgap > 0) begin
        req_valid[i] = 1'b0;
        repeat ($urandom_range(maxgap, 0)) @(posedge control_clk);
        #1;
      end
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(posedge control_clk); #1;
      if (sb.size() == 0 && !busy_now()) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0; int c1;
    for (int k = 0; k < NREQ; k++) acc_cnt[k] = 0;
    control_rst_n = 1'b0;
    repeat (3) @(posedge control_clk);
    #1 control_rst_n = 1'b1;
    @(negedge control_clk);
    chk("rst_ctl", 64'({we, cs, sel, addr, rsp_valid, req_ready}), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_rin", r_in, 64'd0);
    @(posedge control_clk); #1;

    // write from req0, then read it back through req1
    set_fields(0, 1'b1, 9'h001, 2'd0, 7'd0, 64'hDEAD_BEEF_0123_4567);
    req_valid[0] = 1'b1;
    #1 chk("ready_comb", 64'(req_ready), 64'd1);
    wait_acc(0);
    req_valid[0] = 1'b0;
    drain();
    chk("wr_rdata_zero", rsp_rdata, 64'd0);
    set_fields(1, 1'b0, 9'h001, 2'd0, 7'd0, 64'd0);
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    drain();
    chk("rd_back", rsp_rdata, 64'hDEAD_BEEF_0123_4567);

    // continuous contention: 4 reads each must alternate at minimum spacing
    s0 = acc_owner.size();
    fork
      drive(0, 4, 0, 1'b1);
      drive(1, 4, 0, 1'b1);
    join
    drain();
    chk("contention_cnt", 64'(acc_owner.size() - s0), 64'd8);
    for (int k = s0 + 1; k < acc_owner.size(); k++) begin
      chk("alternate", 64'(acc_owner[k] != acc_owner[k-1]), 64'd1);
      chk("spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(RD_LAT + 2));
    end

    // firmware date register with multi-cycle read latency
    set_fields(0, 1'b0, 9'h001, 2'd0, 7'h18, 64'd0);
    req_valid[0] = 1'b1;
    wait_acc(0);
    req_valid[0] = 1'b0;
    drain();
    chk("fw_date", rsp_rdata, FW_DATE);

    // cs=0 read still completes, returning 0
    set_fields(1, 1'b0, 9'h000, 2'd0, 7'd0, 64'd0);
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    drain();
    chk("cs0_read", rsp_rdata, 64'd0);

    // a request withdrawn before grant issues nothing
    set_fields(0, 1'b0, 9'h001, 2'd1, 7'd2, 64'd0);
    req_valid[0] = 1'b1;
    wait_acc(0);
    req_valid[0] = 1'b0;
    c1 = acc_cnt[1];
    set_fields(1, 1'b1, 9'h001, 2'd1, 7'd3, 64'h1111);
    req_valid[1] = 1'b1;
    @(posedge control_clk); #1;
    req_valid[1] = 1'b0;
    drain();
    chk("withdraw", 64'(acc_cnt[1] - c1), 64'd0);

    // reset in HOLD of a req0 read: no response, pointer back to 0
    set_fields(0, 1'b0, 9'h001, 2'd0, 7'd0, 64'd0);
    req_valid[0] = 1'b1;
    wait_acc(0);
    req_valid[0] = 1'b0;
    @(posedge control_clk); #1;
    control_rst_n = 1'b0;
    @(posedge control_clk); #1;
    control_rst_n = 1'b1;
    @(negedge control_clk);
    chk("rst_abort_ctl", 64'({we, cs, sel, addr, rsp_valid}), 64'd0);
    chk("rst_abort_rin", r_in, 64'd0);
    repeat (RD_LAT + 3) @(posedge control_clk);
    #1;
    set_fields(0, 1'b0, 9'h001, 2'd0, 7'd1, 64'd0);
    set_fields(1, 1'b0, 9'h001, 2'd0, 7'd2, 64'd0);
    req_valid = '1;
    #1 chk("rst_ptr", 64'(req_ready), 64'd1);
    wait_acc(0);
    req_valid[0] = 1'b0;
    wait_acc(1);
    req_valid[1] = 1'b0;
    drain();

`ifdef REGBANK_ARB_LOCK_EN
    // locked read, locked write, unlocked write from req1 with req0 waiting
    s0 = acc_owner.size();
    set_fields(1, 1'b0, 9'h001, 2'd0, 7'd4, 64'd0);
    req_lock[1] = 1'b1;
    req_valid[1] = 1'b1;
    wait_acc(1);
    set_fields(0, 1'b0, 9'h001, 2'd0, 7'd4, 64'd0);
    req_valid[0] = 1'b1;
    set_fields(1, 1'b1, 9'h001, 2'd0, 7'd4, 64'hAAAA_5555);
    wait_acc(1);
    set_fields(1, 1'b1, 9'h001, 2'd0, 7'd4, 64'hBBBB_6666);
    req_lock[1] = 1'b0;
    wait_acc(1);
    req_valid[1] = 1'b0;
    wait_acc(0);
    req_valid[0] = 1'b0;
    drain();
    chk("lock_cnt", 64'(acc_owner.size() - s0), 64'd4);
    if (acc_owner.size() - s0 == 4) begin
      chk("lock_seq", 64'({acc_owner[s0][3:0], acc_owner[s0+1][3:0],
                           acc_owner[s0+2][3:0], acc_owner[s0+3][3:0]}), 64'h1110);
    end
    chk("lock_rdback", rsp_rdata, 64'hBBBB_6666);
`endif

    // randomized traffic with gaps
    fork
      drive(0, 15, 4, 1'b0);
      drive(1, 15, 4, 1'b0);
    join
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Round-robin arbiter that shares one register_bank control port (cs/sel/addr/r_in/we/r_out) between NREQ requesters, e.g. the host link and an internal config sequencer.
- Serialises single-word read/write transactions, drives the bank signals for the correct number of cycles, and captures the registered r_out.
- Returns a response pulse to the requester that issued the transaction.
- Sits between the control-bus masters and register_bank in the control_clk domain.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- RD_LAT, 1, cycles from the bank address appearing until r_out is valid; legal range 1..4.

Ports:
- control_clk  in  1  control clock; all logic on its rising edge.
- control_rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  NREQ  per-requester transaction request.
- req_we  in  NREQ  1 = write, 0 = read.
- req_cs  in  NREQ*9  chip selects, requester i at [9i+8:9i].
- req_sel  in  NREQ*2  bank select, requester i at [2i+1:2i].
- req_addr  in  NREQ*7  register address, requester i at [7i+6:7i].
- req_wdata  in  NREQ*64  write data, requester i at [64i+63:64i].
- req_ready  out  NREQ  one-hot grant; the transaction is accepted on the edge where req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  64  read data; 0 for writes.
- cs  out  9  to register_bank.
- sel  out  2  to register_bank.
- addr  out  7  to register_bank.
- r_in  out  64  to register_bank.
- we  out  1  to register_bank.
- r_out  in  64  from register_bank.

Behaviour:
- Reset (control_rst_n=0 at an edge):
  - state=IDLE, round-robin pointer=0.
  - cs, sel, addr, r_in, we, rsp_valid, rsp_rdata all 0.
- A mid-transaction reset aborts the transaction with no rsp_valid. A write whose we pulse has already been sampled by the bank stays committed.
- States: IDLE, HOLD, CAPT.
- IDLE:
  - req_ready is combinational. It is one-hot on the first requester with req_valid set, searching from the pointer upward with wrap from NREQ-1 to 0.
  - req_ready is 0 when no requester is valid.
  - Bank outputs are all 0.
- Accept edge T0, for granted requester g:
  - Register cs/sel/addr/r_in from g's fields; r_in=0 for reads. Register we=req_we[g].
  - Latch owner=g and the transaction type.
  - Pointer becomes (g+1) mod NREQ.
  - Go to HOLD with counter=RD_LAT.
- HOLD:
  - cs/sel/addr/r_in stay stable.
  - we is high only in the first cycle after T0 and is cleared at edge T0+1.
  - Counter decrements each edge. At count 1, go to CAPT.
- CAPT, one cycle:
  - On its closing edge (T0+RD_LAT+1), latch rsp_rdata = r_out for reads, or 0 for writes.
  - On the same edge, set rsp_valid[owner]=1, clear cs/sel/addr/r_in to 0, and return to IDLE.
- rsp_valid is high for exactly one cycle: T0+RD_LAT+1 to T0+RD_LAT+2.
- rsp_rdata holds its value until the next completion.
- req_ready may assert in the same cycle as rsp_valid.
- Minimum spacing between accepts is RD_LAT+2 cycles.
- req_ready is 0 in HOLD and CAPT. Requests raised then wait; nothing is queued inside the arbiter.
- A requester may drop req_valid before it is granted; nothing is issued for it.
- Request fields are sampled only on the accept edge; changes afterwards are ignored.
- cs is forwarded unmodified, including cs=0. A cs=0 read still completes with whatever r_out returns (0 from register_bank).

Optional Feature:
- Macro REGBANK_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NREQ].
  - If the accepted transaction has req_lock[g]=1, the arbiter enters locked mode with lock_owner=g.
  - In locked mode, IDLE grants only lock_owner, the pointer does not advance, and other requesters wait.
  - Lock clears when lock_owner completes a transaction accepted with req_lock[g]=0, or on reset.
  - Use: atomic read-modify-write sequences.
- Not defined: no req_lock port, pure round-robin.

Test Plan:
- Reset then an idle bench -> all outputs 0, req_ready=0. Then req_valid=2'b01 -> req_ready=2'b01 combinationally.
- Write from req0 (cs=9'h001, sel=0, addr=0, wdata=64'hDEAD_BEEF_0123_4567), then read from req1 of the same address, RD_LAT=1:
  - we is high exactly one cycle.
  - rsp_valid[0] pulses at T0+2 with rsp_rdata=0.
  - The read returns rsp_rdata=64'hDEAD_BEEF_0123_4567 on rsp_valid[1].
- Both requesters hold req_valid continuously with 4 reads each:
  - Grants alternate 0,1,0,1,…
  - Accepts are spaced exactly RD_LAT+2 cycles.
  - Each rsp_valid goes only to its owner.
- Read of addr 7'h18, sel=0, cs=9'h001 with RD_LAT=3 and the bank model delaying r_out 3 cycles -> rsp_rdata equals the model's fw_date value, rsp_valid at T0+4.
- control_rst_n pulled low in HOLD of a read -> no rsp_valid, next cycle all bank outputs 0, pointer=0 (req0 wins the next contention).
- With REGBANK_ARB_LOCK_EN defined:
  - req1 reads with lock=1 while req0 is pending; req0 is not granted while req1 issues a further locked write.
  - req1's unlocked final write completes, after which req0 is granted next.
